wb_regfile: RTL
===============

// Module: wb_regfile
// PURPOSE
//  Writeback stage plus architectural register file; consumes the MEM/WB pipeline register outputs.
//  Selects the writeback value (ALU / memory / link), commits it to the 32-entry register file.
//  Serves two combinational read ports to ID, with write-first bypass.
//  Counts committed writes and flags illegal selector codes for debug.
// PARAMETERS
//  XLEN   32  data width of registers and writeback buses
//  NREGS  32  number of architectural registers (x0 hardwired zero)
//  AW     5   register address width, log2(NREGS)
//  CNT_W  32  width of committed-write counter
// PORTS
//  clk            in   1      clock, all state updates on rising edge
//  reset_n        in   1      reset, synchronous, active-low
//  wb_regwrite    in   1      RegWrite from MEM/WB register
//  wb_mem2reg     in   2      writeback select: 00 ALU, 01 MEM, 10 JAL, 11 reserved
//  wb_alu_result  in   XLEN   ALU result from MEM/WB register
//  wb_mem_result  in   XLEN   load data from MEM/WB register
//  wb_jal_result  in   XLEN   link address (PC+4) from MEM/WB register
//  wb_rd          in   AW     destination register number
//  rs1_addr       in   AW     read port 1 address (ID stage)
//  rs2_addr       in   AW     read port 2 address (ID stage)
//  rs1_data       out  XLEN   read port 1 data, combinational
//  rs2_data       out  XLEN   read port 2 data, combinational
//  wb_data        out  XLEN   selected writeback value, combinational (for EX forwarding)
//  wb_we          out  1      effective write enable this cycle, combinational
//  wb_count       out  CNT_W  number of committed writes since reset
//  bad_sel        out  1      sticky: wb_regwrite=1 seen with wb_mem2reg=11
// BEHAVIOUR
//  Mux: wb_data = ALU/MEM/JAL per wb_mem2reg; code 11 -> wb_data = 0.
//  wb_we = reset_n & wb_regwrite & (wb_rd != 0) & (wb_mem2reg != 11).
//  Commit: on rising clk with wb_we=1, regs[wb_rd] <= wb_data; exactly one write per cycle.
//  x0: never written; reads of address 0 always return 0, including via bypass.
//  Read: rsN_data = (wb_we && rsN_addr == wb_rd) ? wb_data : regs[rsN_addr].
//   Write-first bypass, zero-latency: ID sees same-cycle WB value; no extra stall needed.
//   Both ports may hit the bypass simultaneously; both return wb_data.
//  Reset: at rising clk with reset_n=0: all regs[1..NREGS-1] <= 0, wb_count <= 0, bad_sel <= 0.
//   While reset_n=0: wb_we=0, no commit, no count, rs1_data=rs2_data=0.
//   Reset asserted mid-stream discards the in-flight WB write of that cycle.
//  wb_count: +1 on every commit (wb_we=1); wraps modulo 2^CNT_W, no saturation.
//  bad_sel: set at rising clk when reset_n=1 & wb_regwrite=1 & wb_mem2reg=11; cleared only by reset.
//   An illegal-select cycle performs no write and no count.
//  wb_regwrite=0: no write regardless of wb_rd / wb_mem2reg; bad_sel unaffected.
//  All reads and wb_data are pure combinational on current inputs and state; no X on outputs after reset.
// TESTING
//  Reset, then read all 32 addresses -> all 0; wb_count=0, bad_sel=0.
//  regwrite=1, mem2reg=00, alu=0x1234_5678, rd=5; next cycle rs1_addr=5 -> 0x1234_5678, wb_count=1.
//  Same cycle: rd=7, mem2reg=01, mem=0xDEAD_BEEF, rs1=rs2=7 -> both return 0xDEAD_BEEF (bypass).
//  regwrite=1, rd=0, mem2reg=10, jal=0x40 -> rs1_addr=0 reads 0; wb_count unchanged.
//  regwrite=1, mem2reg=11, rd=3 -> bad_sel=1 next cycle, x3 unchanged, count unchanged.
//  Write x9=0xA5A5_A5A5, then reset_n=0 for one cycle while writing x10=0x1 -> x9=0, x10=0, count=0.

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback stage and 32-entry architectural register file.
// Write-first bypass to ID, committed-write counter and sticky bad-select flag.
module wb_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            wb_regwrite,
  input  logic [1:0]      wb_mem2reg,
  input  logic [XLEN-1:0] wb_alu_result,
  input  logic [XLEN-1:0] wb_mem_result,
  input  logic [XLEN-1:0] wb_jal_result,
  input  logic [AW-1:0]   wb_rd,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_we,
  output logic [CNT_W-1:0] wb_count,
  output logic            bad_sel
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [CNT_W-1:0] r_count;
  logic             r_bad;
  logic [XLEN-1:0]  w_data;
  logic             w_we;
  logic             w_illegal;

  always_comb begin
    w_data = '0;
    unique case (wb_mem2reg)
      2'b00:   w_data = wb_alu_result;
      2'b01:   w_data = wb_mem_result;
      2'b10:   w_data = wb_jal_result;
      default: w_data = '0;
    endcase
  end

  assign w_illegal = wb_regwrite & (wb_mem2reg == 2'b11);
  assign w_we = reset_n & wb_regwrite & (wb_rd != '0)
              & (wb_mem2reg != 2'b11);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_count <= '0;
      r_bad   <= 1'b0;
    end else begin
      if (w_we) begin
        r_regs[wb_rd] <= w_data;
        r_count       <= r_count + CNT_W'(1);
      end
      if (w_illegal) r_bad <= 1'b1;
    end
  end

  // x0 reads as zero even when the bypass would match
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (reset_n && rs1_addr != '0)
      rs1_data = (w_we && rs1_addr == wb_rd) ? w_data : r_regs[rs1_addr];
    if (reset_n && rs2_addr != '0)
      rs2_data = (w_we && rs2_addr == wb_rd) ? w_data : r_regs[rs2_addr];
  end

  assign wb_data  = w_data;
  assign wb_we    = w_we;
  assign wb_count = r_count;
  assign bad_sel  = r_bad;

endmodule
